// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the sequencer and the datapath/memory side
interface multicycle_controller_if;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ready;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        rf_we;
  logic        mem_to_reg;
  logic [1:0]  alu_op_mode;
  logic [1:0]  alu_src;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;
  logic [31:0] instr_cnt;

  modport master (
    input  opcode, br_taken, mem_ready,
    output ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel,
           rf_we, mem_to_reg, alu_op_mode, alu_src,
           state, illegal, timeout, instr_cnt
  );

  modport slave (
    output opcode, br_taken, mem_ready,
    input  ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel,
           rf_we, mem_to_reg, alu_op_mode, alu_src,
           state, illegal, timeout, instr_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle instruction sequencer with bounded memory handshakes
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_REG = 3'd0, CL_IMM = 3'd1, CL_LOAD = 3'd2, CL_STORE = 3'd3, CL_BRANCH = 3'd4
  } class_e;

  state_e        state_q, state_d;
  class_e        class_q, class_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   cnt_q, cnt_d;

  logic       ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, rf_we, mem_to_reg;
  logic [1:0] alu_op_mode, alu_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      class_q   <= CL_IMM;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes are held low while rst is asserted so a pending write is abandoned at once.
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    wait_d       = wait_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    mem_to_reg   = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_we   = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          state_d = EXEC;
          case (bus.opcode)
            7'b0110011: class_d = CL_REG;
            7'b0010011: class_d = CL_IMM;
            7'b0000011: class_d = CL_LOAD;
            7'b0100011: class_d = CL_STORE;
            7'b1100011: class_d = CL_BRANCH;
            default: begin
              illegal_d = 1'b1;
              state_d   = HALT;
            end
          endcase
        end
        EXEC: begin
          case (class_q)
            CL_BRANCH: begin
              pc_we   = 1'b1;
              pc_src  = bus.br_taken;
              state_d = FETCH;
            end
            CL_LOAD, CL_STORE: state_d = MEM;
            default:           state_d = WB;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (class_q == CL_STORE);
          if (bus.mem_ready) begin
            if (class_q == CL_STORE) begin
              pc_we   = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = WB;
            end
          end
        end
        WB: begin
          rf_we      = 1'b1;
          mem_to_reg = (class_q == CL_LOAD);
          pc_we      = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = HALT;
      endcase

      // A ready arriving on the WAIT_MAX cycle still completes the handshake.
      if (mem_req && !bus.mem_ready) begin
        if (wait_q == WAIT_MAX) begin
          timeout_d = 1'b1;
          state_d   = HALT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      if ((state_d == FETCH || state_d == MEM) && state_d != state_q) wait_d = '0;
      if (pc_we) cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    alu_op_mode = 2'b00;
    alu_src     = 2'b01;
    case (class_q)
      CL_REG: begin
        alu_src     = 2'b00;
        alu_op_mode = 2'b01;
      end
      CL_STORE:  alu_src = 2'b10;
      CL_BRANCH: alu_src = 2'b11;
      default:   alu_src = 2'b01;
    endcase
  end

  assign bus.ir_we        = ir_we;
  assign bus.pc_we        = pc_we;
  assign bus.pc_src       = pc_src;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.rf_we        = rf_we;
  assign bus.mem_to_reg   = mem_to_reg;
  assign bus.alu_op_mode  = alu_op_mode;
  assign bus.alu_src      = alu_src;
  assign bus.state        = state_q;
  assign bus.illegal      = illegal_q;
  assign bus.timeout      = timeout_q;
  assign bus.instr_cnt    = cnt_q;
endmodule
